// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Types shared by the sequential divider core and the div FIFO that feeds it.
//   div_op_t          : the four divide operations (2-bit encoding)
//   div_fifo_entry_t  : one queued operation {rs1, rs2, op, id}
//   div_state_t       : control states of the divider core
// The entry widths come from DIV_XLEN / DIV_ID_WIDTH. A core instantiated
// with other XLEN/ID_WIDTH values needs these localparams changed to match.
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_XLEN     = 32;
    localparam int DIV_ID_WIDTH = 3;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    typedef struct packed {
        logic [DIV_XLEN-1:0]     rs1;
        logic [DIV_XLEN-1:0]     rs2;
        div_op_t                 op;
        logic [DIV_ID_WIDTH-1:0] id;
    } div_fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } div_state_t;

    // DIV and REM treat their operands as two's-complement numbers.
    function automatic logic op_is_signed(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    // REM and REMU return the remainder rather than the quotient.
    function automatic logic op_is_rem(input div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_core_seq.sv
// ---------------------------------------------------------------------------
// div_core_seq
// Multi-cycle restoring radix-2 divider. Pops one operation from the div
// FIFO, spends one cycle forming operand magnitudes, XLEN cycles producing
// one quotient bit each, then holds the result until the consumer acks it.
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset; drops any in-flight op
//   fifo_valid   : the div FIFO has a head entry
//   fifo_data    : head entry {rs1, rs2, op, id}
//   fifo_pop     : head entry is taken this cycle
//   result_valid : result/result_id hold a completed operation
//   result_ack   : consumer takes the result this cycle
//   result       : quotient or remainder
//   result_id    : tag of the completed operation
// ---------------------------------------------------------------------------
module div_core_seq
    import div_pkg::*;
#(
    parameter int XLEN     = DIV_XLEN,
    parameter int ID_WIDTH = DIV_ID_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_valid,
    input  div_fifo_entry_t     fifo_data,
    output logic                fifo_pop,
    output logic                result_valid,
    input  logic                result_ack,
    output logic [XLEN-1:0]     result,
    output logic [ID_WIDTH-1:0] result_id
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    div_state_t state;
    div_state_t state_next;

    // Operation captured at pop time.
    logic [XLEN-1:0]     rs1_q;
    logic [XLEN-1:0]     rs2_q;
    div_op_t             op_q;
    logic [ID_WIDTH-1:0] id_q;

    // Iteration registers: quo_q starts as the dividend magnitude and has
    // quotient bits shifted in from the bottom as dividend bits leave the top.
    logic [XLEN-1:0]     quo_q;
    logic [XLEN-1:0]     rem_q;
    logic [XLEN-1:0]     dvs_q;
    logic                neg_quo_q;
    logic                neg_rem_q;
    logic [CNT_W-1:0]    count_q;

    logic [XLEN-1:0]     result_q;
    logic [ID_WIDTH-1:0] result_id_q;

    // Operand conditioning.
    logic                rs1_neg;
    logic                rs2_neg;
    logic [XLEN-1:0]     rs1_mag;
    logic [XLEN-1:0]     rs2_mag;
    logic                divisor_zero;
    logic [XLEN-1:0]     dz_result;

    // One restoring step.
    logic [XLEN:0]       shifted;
    logic [XLEN:0]       diff;
    logic                sub_ok;
    logic [XLEN-1:0]     rem_step;
    logic [XLEN-1:0]     quo_step;
    logic [XLEN-1:0]     quo_fix;
    logic [XLEN-1:0]     rem_fix;
    logic [XLEN-1:0]     final_result;

    // Magnitudes for the signed ops. The most negative value maps onto
    // itself, which read as unsigned is exactly its magnitude, so the
    // MIN / -1 overflow case falls out with quotient MIN and remainder 0.
    always_comb begin
        rs1_neg      = op_is_signed(op_q) & rs1_q[XLEN-1];
        rs2_neg      = op_is_signed(op_q) & rs2_q[XLEN-1];
        rs1_mag      = rs1_neg ? ({XLEN{1'b0}} - rs1_q) : rs1_q;
        rs2_mag      = rs2_neg ? ({XLEN{1'b0}} - rs2_q) : rs2_q;
        divisor_zero = (rs2_q == {XLEN{1'b0}});
        dz_result    = op_is_rem(op_q) ? rs1_q : {XLEN{1'b1}};
    end

    // The partial remainder is widened by one bit so the trial subtraction's
    // borrow is visible; a clear borrow means the divisor fits this step.
    always_comb begin
        shifted      = {rem_q, quo_q[XLEN-1]};
        diff         = shifted - {1'b0, dvs_q};
        sub_ok       = ~diff[XLEN];
        rem_step     = sub_ok ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_step     = {quo_q[XLEN-2:0], sub_ok};
        quo_fix      = neg_quo_q ? ({XLEN{1'b0}} - quo_step) : quo_step;
        rem_fix      = neg_rem_q ? ({XLEN{1'b0}} - rem_step) : rem_step;
        final_result = op_is_rem(op_q) ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The pop is masked during reset so no entry is lost to a cycle that is
    // about to be discarded anyway.
    always_comb begin
        state_next   = state;
        fifo_pop     = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_valid && !rst) begin
                    fifo_pop   = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = divisor_zero ? DONE : DIVIDE;
            end
            DIVIDE: begin
                if (count_q == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result registers are only written on the way into DONE, so they stay
    // put for however long the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_q       <= '0;
            rs2_q       <= '0;
            op_q        <= DIV;
            id_q        <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            count_q     <= '0;
            result_q    <= '0;
            result_id_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        rs1_q <= fifo_data.rs1;
                        rs2_q <= fifo_data.rs2;
                        op_q  <= fifo_data.op;
                        id_q  <= fifo_data.id;
                    end
                end
                SETUP: begin
                    quo_q     <= rs1_mag;
                    dvs_q     <= rs2_mag;
                    rem_q     <= '0;
                    neg_quo_q <= rs1_neg ^ rs2_neg;
                    neg_rem_q <= rs1_neg;
                    count_q   <= CNT_W'(XLEN - 1);
                    if (divisor_zero) begin
                        result_q    <= dz_result;
                        result_id_q <= id_q;
                    end
                end
                DIVIDE: begin
                    quo_q   <= quo_step;
                    rem_q   <= rem_step;
                    count_q <= count_q - CNT_W'(1);
                    if (count_q == '0) begin
                        result_q    <= final_result;
                        result_id_q <= id_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result    = result_q;
    assign result_id = result_id_q;

endmodule

// File: tb/tb_div_core_seq.sv
// ---------------------------------------------------------------------------
// tb_div_core_seq
// Directed bench for div_core_seq (XLEN=32, ID_WIDTH=3). Each test task
// drives its scenario and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_div_core_seq;
    import div_pkg::*;

    logic            clk;
    logic            rst;
    logic            fifo_valid;
    div_fifo_entry_t fifo_data;
    logic            fifo_pop;
    logic            result_valid;
    logic            result_ack;
    logic [31:0]     result;
    logic [2:0]      result_id;

    int errors = 0;
    int checks = 0;
    int pop_count = 0;
    bit watch_id5 = 0;
    bit seen_id5 = 0;

    div_core_seq #(.XLEN(32), .ID_WIDTH(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_valid   (fifo_valid),
        .fifo_data    (fifo_data),
        .fifo_pop     (fifo_pop),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .result       (result),
        .result_id    (result_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every pop the core actually performs.
    always @(posedge clk) begin
        if (fifo_pop === 1'b1) pop_count++;
        if (watch_id5 && result_valid === 1'b1 && result_id === 3'd5) seen_id5 = 1;
    end

    // Issue one operation with fifo_valid held high until the result shows,
    // so any extra pop would be visible. lat counts edges from the pop edge.
    task automatic run_op(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] id, input bit do_ack,
                          output logic [31:0] res, output logic [2:0] rid,
                          output int lat, output int pops, output logic first_pop);
        int p0;
        fifo_data  = '{rs1: a, rs2: b, op: op, id: id};
        fifo_valid = 1'b1;
        #1;
        first_pop = fifo_pop;
        p0  = pop_count;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (result_valid !== 1'b1 && lat < 100);
        fifo_valid = 1'b0;
        res  = result;
        rid  = result_id;
        pops = pop_count - p0;
        if (do_ack) begin
            result_ack = 1'b1;
            @(posedge clk); #1;
            result_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        fifo_valid = 1'b1;
        fifo_data  = '{rs1: 32'd9, rs2: 32'd3, op: DIVU, id: 3'd1};
        result_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (fifo_pop !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_pop got=%b exp=0", fifo_pop);
        end
        checks++;
        if (result_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_valid got=%b exp=0", result_valid);
        end
        checks++;
        if (result !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_result got=%h exp=0", result);
        end
        checks++;
        if (result_id !== 3'd0) begin
            errors++; $display("[TB] FAIL reset_id got=%0d exp=0", result_id);
        end
        fifo_valid = 1'b0;
        rst        = 1'b0;
        @(posedge clk); #1;
    endtask

    // One directed vector: value, tag, latency and pop count.
    task automatic check_vector(input string name, input div_op_t op, input logic [31:0] a,
                                input logic [31:0] b, input logic [2:0] id,
                                input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res; logic [2:0] rid; int lat; int pops; logic fp;
        run_op(op, a, b, id, 1'b1, res, rid, lat, pops, fp);
        checks++;
        if (res !== exp_res) begin
            errors++; $display("[TB] FAIL %s_result got=%h exp=%h", name, res, exp_res);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++; $display("[TB] FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat);
        end
        checks++;
        if (rid !== id) begin
            errors++; $display("[TB] FAIL %s_id got=%0d exp=%0d", name, rid, id);
        end
        checks++;
        if (pops != 1) begin
            errors++; $display("[TB] FAIL %s_pops got=%0d exp=1", name, pops);
        end
    endtask

    task automatic test_unsigned();
        check_vector("divu_100_7", DIVU, 32'd100, 32'd7, 3'd2, 32'd14, 34);
        check_vector("remu_100_7", REMU, 32'd100, 32'd7, 3'd3, 32'd2, 34);
        check_vector("divu_big",   DIVU, 32'hFFFFFFFF, 32'd16, 3'd4, 32'h0FFFFFFF, 34);
    endtask

    task automatic test_signed();
        check_vector("div_m7_2",  DIV, 32'hFFFFFFF9, 32'd2, 3'd1, 32'hFFFFFFFD, 34);
        check_vector("rem_m7_2",  REM, 32'hFFFFFFF9, 32'd2, 3'd2, 32'hFFFFFFFF, 34);
        check_vector("div_7_m2",  DIV, 32'd7, 32'hFFFFFFFE, 3'd3, 32'hFFFFFFFD, 34);
        check_vector("rem_7_m2",  REM, 32'd7, 32'hFFFFFFFE, 3'd4, 32'd1, 34);
    endtask

    task automatic test_div_zero();
        check_vector("div_zero",  DIV,  32'h12345678, 32'd0, 3'd5, 32'hFFFFFFFF, 2);
        check_vector("rem_zero",  REM,  32'h12345678, 32'd0, 3'd6, 32'h12345678, 2);
        check_vector("divu_zero", DIVU, 32'h00000055, 32'd0, 3'd7, 32'hFFFFFFFF, 2);
        check_vector("remneg_zero", REM, 32'hFFFFFFF9, 32'd0, 3'd0, 32'hFFFFFFF9, 2);
    endtask

    task automatic test_overflow();
        check_vector("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 3'd1, 32'h80000000, 34);
        check_vector("rem_ovf", REM, 32'h80000000, 32'hFFFFFFFF, 3'd2, 32'd0, 34);
    endtask

    // An ack held high while the core is busy must not disturb the result.
    task automatic test_ack_ignored();
        logic [31:0] res; logic [2:0] rid; int lat; int pops; logic fp;
        result_ack = 1'b1;
        run_op(DIVU, 32'd81, 32'd9, 3'd3, 1'b1, res, rid, lat, pops, fp);
        checks++;
        if (res !== 32'd9) begin
            errors++; $display("[TB] FAIL early_ack_result got=%h exp=9", res);
        end
        checks++;
        if (lat != 34) begin
            errors++; $display("[TB] FAIL early_ack_latency got=%0d exp=34", lat);
        end
    endtask

    task automatic test_stall();
        logic [31:0] res; logic [2:0] rid; int lat; int pops; logic fp;
        logic [31:0] res2; logic [2:0] rid2;
        run_op(DIVU, 32'd1000, 32'd10, 3'd6, 1'b0, res, rid, lat, pops, fp);
        checks++;
        if (res !== 32'd100) begin
            errors++; $display("[TB] FAIL stall_result got=%h exp=64", res);
        end
        fifo_data  = '{rs1: 32'd50, rs2: 32'd5, op: DIVU, id: 3'd7};
        fifo_valid = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (fifo_pop !== 1'b0 || result_valid !== 1'b1 || result !== 32'd100 || result_id !== 3'd6) begin
                errors++;
                $display("[TB] FAIL stall_hold cyc=%0d got pop=%b v=%b res=%h id=%0d exp pop=0 v=1 res=64 id=6",
                         i, fifo_pop, result_valid, result, result_id);
            end
            @(posedge clk); #1;
        end
        result_ack = 1'b1;
        #1;
        checks++;
        if (fifo_pop !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_ack_cycle_pop got=%b exp=0", fifo_pop);
        end
        @(posedge clk); #1;
        result_ack = 1'b0;
        checks++;
        if (fifo_pop !== 1'b1) begin
            errors++; $display("[TB] FAIL stall_next_pop got=%b exp=1", fifo_pop);
        end
        run_op(DIVU, 32'd50, 32'd5, 3'd7, 1'b1, res2, rid2, lat, pops, fp);
        checks++;
        if (res2 !== 32'd10 || rid2 !== 3'd7) begin
            errors++; $display("[TB] FAIL stall_followup got=%h/%0d exp=a/7", res2, rid2);
        end
    endtask

    // Reset during DIVIDE iteration 5 drops the op; the next one still works.
    task automatic test_reset_midop();
        logic [31:0] res; logic [2:0] rid; int lat; int pops; logic fp;
        watch_id5  = 1;
        fifo_data  = '{rs1: 32'd1000, rs2: 32'd3, op: DIVU, id: 3'd5};
        fifo_valid = 1'b1;
        @(posedge clk); #1;
        fifo_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (result_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_valid got=%b exp=0", result_valid);
        end
        checks++;
        if (result_id !== 3'd0) begin
            errors++; $display("[TB] FAIL midrst_id got=%0d exp=0", result_id);
        end
        run_op(DIVU, 32'd1000, 32'd3, 3'd6, 1'b1, res, rid, lat, pops, fp);
        checks++;
        if (fp !== 1'b1) begin
            errors++; $display("[TB] FAIL midrst_idle_pop got=%b exp=1", fp);
        end
        checks++;
        if (res !== 32'd333 || rid !== 3'd6) begin
            errors++; $display("[TB] FAIL midrst_next got=%h/%0d exp=14d/6", res, rid);
        end
        checks++;
        if (lat != 34) begin
            errors++; $display("[TB] FAIL midrst_latency got=%0d exp=34", lat);
        end
        repeat (5) begin
            @(posedge clk); #1;
        end
        checks++;
        if (seen_id5 != 0) begin
            errors++; $display("[TB] FAIL midrst_ghost got=%0d exp=0", seen_id5);
        end
        watch_id5 = 0;
    endtask

    initial begin
        rst        = 1'b0;
        fifo_valid = 1'b0;
        result_ack = 1'b0;
        fifo_data  = '{rs1: 32'd0, rs2: 32'd0, op: DIV, id: 3'd0};
        @(posedge clk); #1;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ack_ignored();
        test_stall();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
